switch_debounce: RTL

- Multi-channel debouncer for raw mechanical switch/button inputs from board pins.
- Sits directly upstream of the LED blink-rate selector and drives its switch and enable inputs with clean, clock-synchronous levels.
- Each channel has a 2-flop synchronizer, a per-channel stability counter, a debounced level output, and one-cycle rise/fall event pulses.

---
 rtl/switch_debounce.sv | 71 +++++++
 1 files changed

// File: rtl/switch_debounce.sv
// Multi-channel switch debouncer.
// Each channel: 2-flop synchronizer, stability counter, debounced level and
// one-cycle rise/fall pulses. All outputs come straight from flops.
module switch_debounce #(
  parameter int NUM_SW         = 3,
  parameter int C_DEBOUNCE_CNT = 250,
  parameter int C_CNT_W        = 32
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic [NUM_SW-1:0] i_switch,
  output logic [NUM_SW-1:0] o_switch,
  output logic [NUM_SW-1:0] o_rise,
  output logic [NUM_SW-1:0] o_fall
);

  // Last count value before a new level is accepted.
  localparam logic [C_CNT_W-1:0] CNT_MAX = C_CNT_W'(C_DEBOUNCE_CNT - 1);
  localparam logic [C_CNT_W-1:0] CNT_ONE = C_CNT_W'(1);

  logic [NUM_SW-1:0]              sync1_q, sync2_q;
  logic [NUM_SW-1:0][C_CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_SW-1:0]              lvl_q, lvl_d;
  logic [NUM_SW-1:0]              rise_q, rise_d;
  logic [NUM_SW-1:0]              fall_q, fall_d;

  // Per-channel accept/reject decision on the synchronized level.
  always_comb begin
    cnt_d  = cnt_q;
    lvl_d  = lvl_q;
    rise_d = '0;
    fall_d = '0;
    for (int ch = 0; ch < NUM_SW; ch++) begin
      if (sync2_q[ch] == lvl_q[ch]) begin
        // Input agrees with output: any partial count is a bounce, discard it.
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] != CNT_MAX) begin
        cnt_d[ch] = cnt_q[ch] + CNT_ONE;
      end else begin
        lvl_d[ch]  = sync2_q[ch];
        cnt_d[ch]  = '0;
        rise_d[ch] = sync2_q[ch];
        fall_d[ch] = ~sync2_q[ch];
      end
    end
  end

  // Synchronizer, counters and registered outputs.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      lvl_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      sync1_q <= i_switch;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_switch = lvl_q;
  assign o_rise   = rise_q;
  assign o_fall   = fall_q;

endmodule
